// File: rtl/muldiv_stall.sv
// Iterative 32-cycle multiply / unsigned divide unit that stalls the ID/EX stage.
// One shift-add or restoring-division step per BUSY cycle; result registered on entry to DONE.
module muldiv_stall (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] acc;   // product accumulator, or partial remainder
    logic [31:0] opa;   // shifting multiplicand, or dividend/quotient shift register
    logic [31:0] opb;   // shifting multiplier, or fixed divisor
    logic [31:0] acc_n, opa_n, opb_n, res_n;
    logic [32:0] rem_sh, diff;

    always_comb begin
        rem_sh = {acc, opa[31]};
        diff   = rem_sh - {1'b0, opb};
        acc_n  = acc;
        opa_n  = opa;
        opb_n  = opb;
        if (op_q == 2'b00) begin
            acc_n = acc + (opb[0] ? opa : 32'd0);
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end else if (!diff[32]) begin
            // A zero divisor always "fits", giving all-ones quotient and dividend remainder
            acc_n = diff[31:0];
            opa_n = {opa[30:0], 1'b1};
        end else begin
            acc_n = rem_sh[31:0];
            opa_n = {opa[30:0], 1'b0};
        end
        case (op_q)
            2'b00:   res_n = acc_n;
            2'b01:   res_n = opa_n;
            2'b10:   res_n = acc_n;
            default: res_n = 32'd0;
        endcase
    end

    // Stall must rise in the same cycle the op is seen so ID/EX holds it.
    assign stall_o = !rst_i && (((state == IDLE) && start_i) || (state == BUSY));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            op_q     <= 2'b00;
            acc      <= 32'd0;
            opa      <= 32'd0;
            opb      <= 32'd0;
            done_o   <= 1'b0;
            result_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_q  <= op_i;
                        opa   <= data1_i;
                        opb   <= data2_i;
                        acc   <= 32'd0;
                        cnt   <= 5'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    opa <= opa_n;
                    opb <= opb_n;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        result_o <= res_n;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    // start_i here still belongs to the departing instruction
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_stall.md
MULDIV_STALL -- requirements
Module: muldiv_stall

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit: the instruction held in the ID/EX register is a multiply/divide op.
REQ-004 SHALL have port op_i, input, 2 bits: 00 MUL (low 32 bits of product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
REQ-005 SHALL have port data1_i, input, 32 bits: operand A (multiplicand / dividend), taken from ID/EX data1.
REQ-006 SHALL have port data2_i, input, 32 bits: operand B (multiplier / divisor), taken from ID/EX data2.
REQ-007 SHALL have port stall_o, output, 1 bit: drives the stall input of the ID/EX register (and the upstream PC and IF/ID hold).
REQ-008 SHALL have port done_o, output, 1 bit: result_o is valid this cycle.
REQ-009 SHALL have port result_o, output, 32 bits: operation result.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-011 SHALL, in IDLE with start_i=1, drive stall_o=1 combinationally in that same cycle, latch op_i, data1_i and data2_i, clear the 5-bit iteration counter, and enter BUSY on the next edge.
REQ-012 SHALL, in IDLE with start_i=0, remain in IDLE with stall_o=0.
REQ-013 SHALL hold stall_o=1 for every BUSY cycle and perform exactly one iteration per cycle for 32 cycles (counter 0..31).
REQ-014 SHALL, on the edge where the counter equals 31, enter DONE; the counter SHALL NOT wrap or continue in DONE.
REQ-015 SHALL compute MUL by shift-add on latched operands; the result is the low 32 bits of the unsigned product, with overflow discarded.
REQ-016 SHALL compute DIVU/REMU by restoring division: 32-bit quotient and 32-bit remainder, unsigned.
REQ-017 SHALL, for a zero divisor, produce quotient 0xFFFFFFFF and remainder equal to the dividend, with the same latency and no exception.
REQ-018 SHALL, for op 11, produce result 0x00000000 with the same latency.
REQ-019 SHALL update result_o on the BUSY-to-DONE edge and hold it unchanged until the next BUSY-to-DONE edge.
REQ-020 SHALL, in DONE, drive stall_o=0 and done_o=1 for exactly one cycle, then return to IDLE.
REQ-021 SHALL ignore start_i during DONE, because it still reflects the instruction now leaving ID/EX; no restart occurs.
REQ-022 SHALL ignore start_i, op_i, data1_i and data2_i changes during BUSY; only the latched copies are used.
REQ-023 SHALL accept a new start_i in the IDLE cycle directly after DONE (back-to-back ops), giving 33 stall cycles per op.
REQ-024 SHALL define latency as: start_i first seen in cycle N; stall_o=1 in cycles N..N+32; done_o=1 in cycle N+33.

Reset
REQ-025 SHALL, while rst_i=1, immediately force state IDLE, counter 0, stall_o=0, done_o=0, result_o=0x00000000 and internal operand/accumulator registers to 0.
REQ-026 SHALL, when rst_i is asserted mid-BUSY, abandon the operation with no done_o pulse; after release, it waits for a fresh start_i.
REQ-027 SHALL, when start_i=1 on the first edge after reset release, begin normally per REQ-011.

Verification
REQ-028 SHALL cover MUL: data1=7, data2=6 -> stall_o high 33 cycles, done_o=1 in the 34th cycle, result_o=0x0000002A.
REQ-029 SHALL cover MUL overflow: 0xFFFFFFFF x 2 -> result_o=0xFFFFFFFE.
REQ-030 SHALL cover DIVU then REMU back-to-back: 100 / 7 -> 0x0000000E, then 100 % 7 -> 0x00000002; the second stall begins in the cycle right after the first done_o.
REQ-031 SHALL cover divide by zero: DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678.
REQ-032 SHALL cover reset at BUSY iteration 10 -> stall_o=0 and result_o=0 immediately, with no done_o pulse; a later MUL 3x5 gives 0x0000000F.
REQ-033 SHALL cover start_i held high through DONE -> exactly one done_o pulse, IDLE reached, and a new op starts only if start_i is still high in IDLE.
